// File: rtl/am2940_ctl.sv
// am2940_ctl: descriptor loader and beat sequencer for an am2940 DMA address generator.
// Loads control, address and word-count registers, then paces device beats until done or abort.
module am2940_ctl (
    input  logic       cp,
    input  logic       rst_,
    input  logic       start,
    input  logic [1:0] cfg_mode,
    input  logic       cfg_dir,
    input  logic [7:0] cfg_addr,
    input  logic [7:0] cfg_cnt,
    input  logic       abort,
    input  logic       irq_ack,
    input  logic       dreq,
    input  logic       done_in,
    output logic [2:0] i,
    output logic [7:0] dout,
    output logic       doe,
    output logic       aci_,
    output logic       wci_,
    output logic       oea_,
    output logic       dack,
    output logic       busy,
    output logic       irq,
    output logic       abt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WCR  = 3'd1,
        S_LDA  = 3'd2,
        S_LDW  = 3'd3,
        S_WAIT = 3'd4,
        S_XFER = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    localparam logic [2:0] I_WCR  = 3'b000;
    localparam logic [2:0] I_RAC  = 3'b011;
    localparam logic [2:0] I_LDA  = 3'b101;
    localparam logic [2:0] I_LDW  = 3'b110;
    localparam logic [2:0] I_ENA  = 3'b111;

    state_t     r_state;
    state_t     w_nxt;
    logic [1:0] r_mode;
    logic       r_dir;
    logic [7:0] r_addr;
    logic [7:0] r_cnt;
    logic       r_irq;
    logic       r_abt;
    logic [2:0] r_i;
    logic [7:0] r_dout;
    logic       r_doe;
    logic       r_aci_n;
    logic       r_wci_n;
    logic       r_oea_n;
    logic       r_dack;
    logic       r_busy;

    logic       w_accept;
    logic       w_abt_set;
    logic [1:0] w_mode_nxt;
    logic       w_dir_nxt;

    // Next-state rule; abort takes priority over dreq, done_in over abort in XFER.
    function automatic state_t f_next(input state_t st, input logic st_start, input logic st_abort,
                                      input logic st_dreq, input logic st_done);
        f_next = st;
        case (st)
            S_IDLE:  f_next = st_start ? S_WCR : S_IDLE;
            S_WCR:   f_next = st_abort ? S_FIN : S_LDA;
            S_LDA:   f_next = st_abort ? S_FIN : S_LDW;
            S_LDW:   f_next = st_abort ? S_FIN : S_WAIT;
            S_WAIT:  f_next = st_abort ? S_FIN : (st_dreq ? S_XFER : S_WAIT);
            S_XFER:  f_next = (st_done || st_abort) ? S_FIN : (st_dreq ? S_XFER : S_WAIT);
            S_FIN:   f_next = S_IDLE;
            default: f_next = S_IDLE;
        endcase
    endfunction

    assign w_nxt      = f_next(r_state, start, abort, dreq, done_in);
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_abt_set  = abort && ((r_state == S_WCR) || (r_state == S_LDA) || (r_state == S_LDW) ||
                                  (r_state == S_WAIT) || ((r_state == S_XFER) && !done_in));
    // Control-word fields as they will be after this edge (WCR is only entered on capture).
    assign w_mode_nxt = w_accept ? cfg_mode : r_mode;
    assign w_dir_nxt  = w_accept ? cfg_dir  : r_dir;

    // State, descriptor, flags, and outputs registered from the decode of the next state.
    always_ff @(posedge cp or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_IDLE;
            r_mode  <= 2'b00;
            r_dir   <= 1'b0;
            r_addr  <= 8'h00;
            r_cnt   <= 8'h00;
            r_irq   <= 1'b0;
            r_abt   <= 1'b0;
            r_i     <= I_RAC;
            r_dout  <= 8'h00;
            r_doe   <= 1'b0;
            r_aci_n <= 1'b1;
            r_wci_n <= 1'b1;
            r_oea_n <= 1'b1;
            r_dack  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt;

            if (w_accept) begin
                r_mode <= cfg_mode;
                r_dir  <= cfg_dir;
                r_addr <= cfg_addr;
                r_cnt  <= cfg_cnt;
            end

            if (r_state == S_FIN) begin
                r_irq <= 1'b1;
            end else if (w_accept || irq_ack) begin
                r_irq <= 1'b0;
            end

            if (w_accept) begin
                r_abt <= 1'b0;
            end else if (w_abt_set) begin
                r_abt <= 1'b1;
            end

            r_i     <= I_RAC;
            r_dout  <= 8'h00;
            r_doe   <= 1'b0;
            r_aci_n <= 1'b1;
            r_wci_n <= 1'b1;
            r_oea_n <= 1'b1;
            r_dack  <= 1'b0;
            r_busy  <= (w_nxt != S_IDLE);
            case (w_nxt)
                S_WCR: begin
                    r_i    <= I_WCR;
                    r_dout <= {5'b00000, w_dir_nxt, w_mode_nxt};
                    r_doe  <= 1'b1;
                end
                S_LDA: begin
                    r_i    <= I_LDA;
                    r_dout <= r_addr;
                    r_doe  <= 1'b1;
                end
                S_LDW: begin
                    r_i    <= I_LDW;
                    r_dout <= r_cnt;
                    r_doe  <= 1'b1;
                end
                S_XFER: begin
                    r_i     <= I_ENA;
                    r_aci_n <= 1'b0;
                    r_wci_n <= 1'b0;
                    r_oea_n <= 1'b0;
                    r_dack  <= 1'b1;
                end
                default: begin
                    r_i <= I_RAC;
                end
            endcase
        end
    end

    assign i    = r_i;
    assign dout = r_dout;
    assign doe  = r_doe;
    assign aci_ = r_aci_n;
    assign wci_ = r_wci_n;
    assign oea_ = r_oea_n;
    assign dack = r_dack;
    assign busy = r_busy;
    assign irq  = r_irq;
    assign abt  = r_abt;

endmodule

// File: tb/tb_am2940_ctl.sv
// Directed bench for am2940_ctl with a phase-level reference model checked every cycle.
module tb_am2940_ctl;

    logic       cp = 1'b0;
    logic       rst_ = 1'b1;
    logic       start = 1'b0;
    logic [1:0] cfg_mode = 2'b00;
    logic       cfg_dir = 1'b0;
    logic [7:0] cfg_addr = 8'h00;
    logic [7:0] cfg_cnt = 8'h00;
    logic       abort = 1'b0;
    logic       irq_ack = 1'b0;
    logic       dreq = 1'b0;
    logic       done_in = 1'b0;
    logic [2:0] i;
    logic [7:0] dout;
    logic       doe, aci_, wci_, oea_, dack, busy, irq, abt;

    am2940_ctl dut (
        .cp(cp), .rst_(rst_), .start(start), .cfg_mode(cfg_mode), .cfg_dir(cfg_dir),
        .cfg_addr(cfg_addr), .cfg_cnt(cfg_cnt), .abort(abort), .irq_ack(irq_ack),
        .dreq(dreq), .done_in(done_in), .i(i), .dout(dout), .doe(doe), .aci_(aci_),
        .wci_(wci_), .oea_(oea_), .dack(dack), .busy(busy), .irq(irq), .abt(abt)
    );

    always #5 cp = ~cp;

    localparam int P_IDLE = 0;
    localparam int P_WCR  = 1;
    localparam int P_LDA  = 2;
    localparam int P_LDW  = 3;
    localparam int P_WAIT = 4;
    localparam int P_XFER = 5;
    localparam int P_FIN  = 6;

    int         m_ph;
    logic       m_irq, m_abt, m_dir;
    logic [1:0] m_mode;
    logic [7:0] m_addr, m_cnt;

    int errors = 0;
    int checks = 0;
    int dack_total = 0;
    int base = 0;
    int cyc = 0;

    // Reference model: which phase of the transfer we are in, plus the two flags.
    always @(posedge cp or negedge rst_) begin
        if (!rst_) begin
            m_ph <= P_IDLE; m_irq <= 1'b0; m_abt <= 1'b0;
            m_mode <= 2'b00; m_dir <= 1'b0; m_addr <= 8'h00; m_cnt <= 8'h00;
        end else begin
            if (m_ph == P_FIN) m_irq <= 1'b1;
            else if (irq_ack) m_irq <= 1'b0;
            case (m_ph)
                P_IDLE: if (start) begin
                    m_mode <= cfg_mode; m_dir <= cfg_dir; m_addr <= cfg_addr; m_cnt <= cfg_cnt;
                    m_irq <= 1'b0; m_abt <= 1'b0; m_ph <= P_WCR;
                end
                P_WCR, P_LDA, P_LDW: begin
                    if (abort) begin m_abt <= 1'b1; m_ph <= P_FIN; end
                    else m_ph <= m_ph + 1;
                end
                P_WAIT: begin
                    if (abort) begin m_abt <= 1'b1; m_ph <= P_FIN; end
                    else if (dreq) m_ph <= P_XFER;
                end
                P_XFER: begin
                    if (done_in) m_ph <= P_FIN;
                    else if (abort) begin m_abt <= 1'b1; m_ph <= P_FIN; end
                    else if (!dreq) m_ph <= P_WAIT;
                end
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    // Expected {i, dout, doe, aci_, wci_, oea_, dack, busy, irq, abt} for the model phase.
    function automatic logic [18:0] model_vec();
        logic [2:0] ei;
        logic [7:0] ed;
        logic       edoe;
        logic       xf;
        xf = (m_ph == P_XFER);
        ei = 3'b011; ed = 8'h00; edoe = 1'b0;
        if (m_ph == P_WCR) begin ei = 3'b000; ed = {5'b00000, m_dir, m_mode}; edoe = 1'b1; end
        else if (m_ph == P_LDA) begin ei = 3'b101; ed = m_addr; edoe = 1'b1; end
        else if (m_ph == P_LDW) begin ei = 3'b110; ed = m_cnt; edoe = 1'b1; end
        else if (xf) ei = 3'b111;
        return {ei, ed, edoe, ~xf, ~xf, ~xf, xf, (m_ph != P_IDLE), m_irq, m_abt};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Advance one cycle, compare all outputs against the model, then release inputs for change.
    task automatic tick();
        @(negedge cp);
        cyc++;
        chk("model", 32'({i, dout, doe, aci_, wci_, oea_, dack, busy, irq, abt}), 32'(model_vec()));
        if (dack === 1'b1) dack_total++;
        #1;
    endtask

    task automatic launch(input logic [1:0] md, input logic dr, input logic [7:0] ad, input logic [7:0] ct);
        cfg_mode = md; cfg_dir = dr; cfg_addr = ad; cfg_cnt = ct;
        base = dack_total;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1 rst_ = 1'b0;
        tick(); tick();
        chk("reset_i_dout_doe", 32'({i, dout, doe}), 32'({3'b011, 8'h00, 1'b0}));
        chk("reset_flags", 32'({aci_, wci_, oea_, dack, busy, irq, abt}), 32'(7'b1110000));
        rst_ = 1'b1;
        tick();

        // Basic load and three back-to-back beats, done on the third.
        dreq = 1'b1; done_in = 1'b0;
        launch(2'd0, 1'b0, 8'h10, 8'h03);
        chk("t1_wcr", 32'({i, dout, doe}), 32'({3'b000, 8'h00, 1'b1}));
        cfg_mode = 2'd2; cfg_dir = 1'b1; cfg_addr = 8'hAA; cfg_cnt = 8'h55;
        tick();
        chk("t1_lda", 32'({i, dout, doe}), 32'({3'b101, 8'h10, 1'b1}));
        tick();
        chk("t1_ldw", 32'({i, dout, doe}), 32'({3'b110, 8'h03, 1'b1}));
        tick();
        chk("t1_wait", 32'({i, doe, busy}), 32'({3'b011, 1'b0, 1'b1}));
        tick(); tick(); tick();
        chk("t1_xfer3", 32'({i, aci_, wci_, oea_, dack}), 32'({3'b111, 4'b0001}));
        done_in = 1'b1;
        tick();
        chk("t1_fin", 32'({i, busy, dack}), 32'({3'b011, 1'b1, 1'b0}));
        done_in = 1'b0;
        tick();
        chk("t1_idle", 32'({busy, irq, abt}), 32'(3'b010));
        chk("t1_dacks", 32'(dack_total - base), 32'd3);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t1_ack", 32'(irq), 32'd0);

        // Alternating dreq: every beat is followed by WAIT.
        dreq = 1'b0;
        launch(2'd0, 1'b0, 8'h10, 8'h03);
        tick(); tick(); tick();
        for (int b = 0; b < 3; b++) begin
            dreq = 1'b1;
            tick();
            chk("t2_xfer", 32'({i, dack}), 32'({3'b111, 1'b1}));
            dreq = 1'b0;
            if (b == 2) done_in = 1'b1;
            tick();
            if (b < 2) chk("t2_wait", 32'({i, dack, busy}), 32'({3'b011, 1'b0, 1'b1}));
        end
        done_in = 1'b0;
        tick();
        chk("t2_idle", 32'({busy, irq, abt}), 32'(3'b010));
        chk("t2_dacks", 32'(dack_total - base), 32'd3);

        // Start while irq is set clears it; start during LDA is ignored; abort in WAIT.
        launch(2'd1, 1'b0, 8'h20, 8'h04);
        chk("t3_irq_clear", 32'({irq, i}), 32'({1'b0, 3'b000}));
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_ldw", 32'({i, dout}), 32'({3'b110, 8'h04}));
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_fin", 32'({i, busy}), 32'({3'b011, 1'b1}));
        tick();
        chk("t3_idle", 32'({busy, irq, abt}), 32'(3'b011));
        chk("t3_dacks", 32'(dack_total - base), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_idle_abort", 32'({busy, irq, abt}), 32'(3'b011));

        // Abort and done together in XFER: beat completes, done wins; irq_ack loses to FIN set.
        dreq = 1'b1;
        launch(2'd0, 1'b0, 8'h30, 8'h01);
        tick(); tick(); tick(); tick();
        abort = 1'b1; done_in = 1'b1;
        tick();
        abort = 1'b0; done_in = 1'b0; irq_ack = 1'b1;
        chk("t4_dacks", 32'(dack_total - base), 32'd1);
        tick();
        irq_ack = 1'b0;
        chk("t4_idle", 32'({busy, irq, abt}), 32'(3'b010));

        // Mode 3 with decrement runs until aborted mid-beat.
        launch(2'd3, 1'b1, 8'hF0, 8'h00);
        chk("t5_wcr", 32'({i, dout}), 32'({3'b000, 8'h07}));
        tick(); tick(); tick();
        repeat (20) tick();
        chk("t5_running", 32'({i, busy}), 32'({3'b111, 1'b1}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("t5_idle", 32'({busy, irq, abt}), 32'(3'b011));
        chk("t5_dacks", 32'(dack_total - base), 32'd20);

        // Reset mid-beat forces outputs inactive without a clock edge.
        launch(2'd0, 1'b0, 8'h40, 8'h08);
        tick(); tick(); tick(); tick();
        chk("t6_in_xfer", 32'({i, dack}), 32'({3'b111, 1'b1}));
        rst_ = 1'b0;
        #1;
        chk("t6_async", 32'({aci_, wci_, oea_, dack, busy, doe, i}), 32'({6'b111000, 3'b011}));
        tick(); tick();
        rst_ = 1'b1;
        tick(); tick();
        chk("t6_after", 32'({busy, irq, abt}), 32'(3'b000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
